// File: rtl/conv_pkg.sv
// Shared types and derived-geometry helpers for the convolution loop sequencer.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic int calc_ow(input int img_w, input int k);
    return img_w - k + 1;
  endfunction

  function automatic int calc_oh(input int img_h, input int k);
    return img_h - k + 1;
  endfunction

  function automatic int calc_taps(input int k);
    return k * k;
  endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth shift register carrying {valid, addr}; the head is the oldest entry.
module valid_delay_line #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_addr,
  output logic         out_valid,
  output logic [W-1:0] out_addr
);

  logic [W:0] stage_q [DEPTH];
  logic [W:0] stage_d [DEPTH];

  // Idle slots carry zero so the head address is 0 whenever it is not valid.
  always_comb begin
    stage_d[0] = in_valid ? {1'b1, in_addr} : '0;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign out_valid = stage_q[DEPTH-1][W];
  assign out_addr  = stage_q[DEPTH-1][W-1:0];

endmodule

// File: rtl/conv_loop_sequencer.sv
// Walks every output pixel and kernel tap of a valid, stride-1 convolution and
// issues buffer read addresses, MAC strobes and latency-aligned output writes.
module conv_loop_sequencer
  import conv_pkg::*;
#(
  parameter int IMG_W   = 8,
  parameter int IMG_H   = 8,
  parameter int K       = 3,
  parameter int LAT     = 2,
  parameter int ADDR_W  = 8,
  parameter int WADDR_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stall,
  output logic               busy,
  output logic               done,
  output logic               rd_valid,
  output logic [ADDR_W-1:0]  in_addr,
  output logic [WADDR_W-1:0] w_addr,
  output logic               mac_clear,
  output logic               mac_last,
  output logic               out_we,
  output logic [ADDR_W-1:0]  out_addr
);

  localparam int OW = calc_ow(IMG_W, K);
  localparam int OH = calc_oh(IMG_H, K);
  localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] kx_q, kx_d, ky_q, ky_d, ox_q, ox_d, oy_q, oy_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic              kx_end, ky_end, ox_end, oy_end;
  logic [ADDR_W-1:0] pix_idx;

  assign kx_end = (kx_q == ADDR_W'(K - 1));
  assign ky_end = (ky_q == ADDR_W'(K - 1));
  assign ox_end = (ox_q == ADDR_W'(OW - 1));
  assign oy_end = (oy_q == ADDR_W'(OH - 1));

  assign rd_valid  = (state_q == RUN) && !stall;
  assign mac_clear = rd_valid && (kx_q == '0) && (ky_q == '0);
  assign mac_last  = rd_valid && kx_end && ky_end;
  assign in_addr   = rd_valid ? (oy_q + ky_q) * ADDR_W'(IMG_W) + ox_q + kx_q : '0;
  assign w_addr    = rd_valid ? WADDR_W'(ky_q * ADDR_W'(K) + kx_q) : '0;
  assign pix_idx   = oy_q * ADDR_W'(OW) + ox_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

  // Counters wrap back to zero on the final tap, so a new run needs no reload.
  always_comb begin
    state_d = state_q;
    kx_d    = kx_q;
    ky_d    = ky_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (rd_valid) begin
          if (!kx_end) kx_d = kx_q + ADDR_W'(1);
          else begin
            kx_d = '0;
            if (!ky_end) ky_d = ky_q + ADDR_W'(1);
            else begin
              ky_d = '0;
              if (!ox_end) ox_d = ox_q + ADDR_W'(1);
              else begin
                ox_d = '0;
                if (!oy_end) oy_d = oy_q + ADDR_W'(1);
                else begin
                  oy_d    = '0;
                  state_d = DRAIN;
                  drain_d = DW'(LAT - 1);
                end
              end
            end
          end
        end
      end
      DRAIN: begin
        if (drain_q == '0) state_d = DONE;
        else drain_d = drain_q - DW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      kx_q    <= '0;
      ky_q    <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      kx_q    <= kx_d;
      ky_q    <= ky_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      drain_q <= drain_d;
    end
  end

  valid_delay_line #(
    .DEPTH (LAT),
    .W     (ADDR_W)
  ) u_out_dly (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (mac_last),
    .in_addr   (pix_idx),
    .out_valid (out_we),
    .out_addr  (out_addr)
  );

endmodule

// File: tb/tb_conv_loop_sequencer.sv
// Scoreboard bench: default-geometry instance A and a 5x4 / K=2 / LAT=3 instance B.
module tb_conv_loop_sequencer;

  localparam int AW = 8;
  localparam int WW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_a = 1'b0, stall_a = 1'b0, start_b = 1'b0, stall_b = 1'b0;

  logic          busy_a, done_a, rdv_a, clr_a, lst_a, we_a;
  logic [AW-1:0] ia_a, oa_a;
  logic [WW-1:0] wa_a;
  logic          busy_b, done_b, rdv_b, clr_b, lst_b, we_b;
  logic [AW-1:0] ia_b, oa_b;
  logic [WW-1:0] wa_b;

  conv_loop_sequencer u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .stall(stall_a),
    .busy(busy_a), .done(done_a), .rd_valid(rdv_a), .in_addr(ia_a), .w_addr(wa_a),
    .mac_clear(clr_a), .mac_last(lst_a), .out_we(we_a), .out_addr(oa_a)
  );

  conv_loop_sequencer #(.IMG_W(5), .IMG_H(4), .K(2), .LAT(3)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .stall(stall_b),
    .busy(busy_b), .done(done_b), .rd_valid(rdv_b), .in_addr(ia_b), .w_addr(wa_b),
    .mac_clear(clr_b), .mac_last(lst_b), .out_we(we_b), .out_addr(oa_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int tapv(input int ia, input int wa, input int c, input int l);
    return ia * 64 + wa * 4 + c * 2 + l;
  endfunction

  // scoreboard state, instance A
  int exp_tap_a[$], exp_out_a[$], mlast_a[$];
  int ntap_a = 0, first_a = 0, lasttap_a = 0, lastml_a = 0, lastdone_a = 0, ndone_a = 0;
  int got_a;
  int log_in[1024], log_w[1024];

  // scoreboard state, instance B
  int exp_tap_b[$], exp_out_b[$], mlast_b[$];
  int ntap_b = 0, last_in_b = 0, last_w_b = 0, nout_b = 0, lastml_b = 0, got_b;

  task automatic push_run_a();
    for (int oy = 0; oy < 6; oy++)
      for (int ox = 0; ox < 6; ox++)
        for (int ky = 0; ky < 3; ky++)
          for (int kx = 0; kx < 3; kx++)
            exp_tap_a.push_back(tapv((oy + ky) * 8 + ox + kx, ky * 3 + kx,
                                     int'(kx == 0 && ky == 0), int'(kx == 2 && ky == 2)));
    for (int p = 0; p < 36; p++) exp_out_a.push_back(p);
  endtask

  task automatic push_run_b();
    for (int oy = 0; oy < 3; oy++)
      for (int ox = 0; ox < 4; ox++)
        for (int ky = 0; ky < 2; ky++)
          for (int kx = 0; kx < 2; kx++)
            exp_tap_b.push_back(tapv((oy + ky) * 5 + ox + kx, ky * 2 + kx,
                                     int'(kx == 0 && ky == 0), int'(kx == 1 && ky == 1)));
    for (int p = 0; p < 12; p++) exp_out_b.push_back(p);
  endtask

  // monitor A: samples 2 time units after the falling edge
  always @(negedge clk) begin
    #2;
    if (!reset) begin
      if (rdv_a) begin
        got_a = tapv(int'(ia_a), int'(wa_a), int'(clr_a), int'(lst_a));
        if (exp_tap_a.size() == 0) chk("tap_a_unexpected", got_a, -1);
        else chk("tap_a", got_a, exp_tap_a.pop_front());
        if (ntap_a % 324 == 0) begin
          if (ntap_a > 0) chk("b2b_gap_a", cyc - lastdone_a, 2);
          first_a = cyc;
        end
        if (ntap_a < 1024) begin
          log_in[ntap_a] = int'(ia_a);
          log_w[ntap_a]  = int'(wa_a);
        end
        lasttap_a = cyc;
        ntap_a++;
        if (lst_a) begin
          mlast_a.push_back(cyc);
          lastml_a = cyc;
        end
      end
      if (we_a) begin
        if (exp_out_a.size() == 0) chk("out_a_unexpected", int'(oa_a), -1);
        else chk("out_addr_a", int'(oa_a), exp_out_a.pop_front());
        if (mlast_a.size() == 0) chk("out_lat_a_nolast", cyc, -1);
        else chk("out_lat_a", cyc - mlast_a.pop_front(), 2);
      end else if (oa_a != '0) begin
        chk("out_addr_idle_a", int'(oa_a), 0);
      end
      if (done_a) begin
        chk("done_lat_a", cyc - lastml_a, 3);
        lastdone_a = cyc;
        ndone_a++;
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (!reset) begin
      if (rdv_b) begin
        got_b = tapv(int'(ia_b), int'(wa_b), int'(clr_b), int'(lst_b));
        if (exp_tap_b.size() == 0) chk("tap_b_unexpected", got_b, -1);
        else chk("tap_b", got_b, exp_tap_b.pop_front());
        last_in_b = int'(ia_b);
        last_w_b  = int'(wa_b);
        ntap_b++;
        if (lst_b) begin
          mlast_b.push_back(cyc);
          lastml_b = cyc;
        end
      end
      if (we_b) begin
        nout_b++;
        if (exp_out_b.size() == 0) chk("out_b_unexpected", int'(oa_b), -1);
        else chk("out_addr_b", int'(oa_b), exp_out_b.pop_front());
        if (mlast_b.size() == 0) chk("out_lat_b_nolast", cyc, -1);
        else chk("out_lat_b", cyc - mlast_b.pop_front(), 3);
      end
      if (done_b) chk("done_lat_b", cyc - lastml_b, 4);
    end
  end

  task automatic pulse_start_a();
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      #1;
      if (done_a) break;
    end
    if (k == budget) chk("timeout_done_a", 0, 1);
  endtask

  task automatic end_run_a(input string name, input int taps, input int span);
    chk({name, "_taps"}, ntap_a, taps);
    chk({name, "_span"}, lasttap_a - first_a + 1, span);
    chk({name, "_tapq_left"}, exp_tap_a.size(), 0);
    chk({name, "_outq_left"}, exp_out_a.size(), 0);
  endtask

  int k_b, nd;

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outs_a", int'({busy_a, done_a, rdv_a, clr_a, lst_a, we_a, ia_a, oa_a, wa_a}), 0);
    reset = 1'b0;

    // nominal run
    ntap_a = 0;
    push_run_a();
    pulse_start_a();
    wait_done_a(500);
    @(negedge clk);
    end_run_a("nominal", 324, 324);
    chk("tap0_in", log_in[0], 0);
    chk("tap0_w", log_w[0], 0);
    chk("tap8_in", log_in[8], 18);
    chk("tap8_w", log_w[8], 8);
    chk("pix1_first_in", log_in[9], 1);
    chk("pix_oy1_first_in", log_in[54], 8);
    chk("last_tap_in", log_in[323], 63);
    chk("done_count", ndone_a, 1);

    // stall 5 cycles on tap 4 of pixel 0
    ntap_a = 0;
    push_run_a();
    pulse_start_a();
    repeat (4) @(negedge clk);
    stall_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #3;
      chk("stall_rdv", int'(rdv_a), 0);
      @(negedge clk);
    end
    stall_a = 1'b0;
    wait_done_a(500);
    @(negedge clk);
    end_run_a("stall", 324, 329);

    // start pulsed in RUN, stall on final tap, start pulsed in DONE
    ntap_a = 0;
    push_run_a();
    pulse_start_a();
    repeat (100) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (222) @(negedge clk);
    stall_a = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #3;
      chk("final_stall_rdv", int'(rdv_a), 0);
      chk("final_stall_busy", int'(busy_a), 1);
      @(negedge clk);
    end
    stall_a = 1'b0;
    wait_done_a(500);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("start_in_done_ignored", int'(busy_a), 0);
    end_run_a("final_stall", 324, 326);

    // start held high: two back-to-back runs
    ntap_a = 0;
    nd = ndone_a;
    push_run_a();
    push_run_a();
    @(negedge clk);
    start_a = 1'b1;
    wait_done_a(500);
    wait_done_a(500);
    start_a = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("b2b_idle_after", int'(busy_a), 0);
    chk("b2b_taps", ntap_a, 648);
    chk("b2b_dones", ndone_a - nd, 2);
    chk("b2b_outq_left", exp_out_a.size(), 0);

    // reset in the middle of a run, with an output write still in flight
    ntap_a = 0;
    push_run_a();
    pulse_start_a();
    repeat (45) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrun_reset_outs", int'({busy_a, done_a, rdv_a, clr_a, lst_a, we_a, ia_a, oa_a, wa_a}), 0);
    exp_tap_a.delete();
    exp_out_a.delete();
    mlast_a.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("midrun_taps_before_reset", ntap_a, 45);
    chk("midrun_idle", int'(busy_a), 0);
    ntap_a = 0;
    push_run_a();
    pulse_start_a();
    wait_done_a(500);
    @(negedge clk);
    end_run_a("after_reset", 324, 324);

    // non-default geometry
    push_run_b();
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (k_b = 0; k_b < 200; k_b++) begin
      @(negedge clk);
      #1;
      if (done_b) break;
    end
    if (k_b == 200) chk("timeout_done_b", 0, 1);
    @(negedge clk);
    chk("b_taps", ntap_b, 48);
    chk("b_last_in", last_in_b, 19);
    chk("b_last_w", last_w_b, 3);
    chk("b_out_count", nout_b, 12);
    chk("b_outq_left", exp_out_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
